// File: rtl/dmem_ctrl.sv
// Word-organised data RAM behind a valid/ready request/response handshake, with RV32 load/store widths.
// Define DMEM_CTRL_FAULT_EN to reject range/alignment/funct3 errors; otherwise addresses wrap and align down.
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_width,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on an edge with req_valid && req_ready, a response on an
  // edge with rsp_valid && rsp_ready; the response stays stable until it transfers.
  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        l_write;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [2:0]  l_width;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic          illegal;
  logic [1:0]    sz;
  logic [1:0]    lane;
  logic          fault;
  logic          access;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign word_off = 30'((l_addr - BASE_ADDR) >> 2);
  assign idx      = AW'({2'b00, word_off} % DEPTH_U);
  assign illegal  = (l_width == 3'b011) || (l_width[2:1] == 2'b11);
  assign sz       = illegal ? 2'd2 : l_width[1:0];
  // Halfwords and words align down; a misaligned access is faulted before this matters.
  assign lane     = (sz == 2'd0) ? l_addr[1:0] :
                    (sz == 2'd1) ? {l_addr[1], 1'b0} : 2'b00;

`ifdef DMEM_CTRL_FAULT_EN
  logic in_range;
  assign in_range = (l_addr >= BASE_ADDR) && ({2'b00, word_off} < DEPTH_U);
  assign fault    = !in_range || illegal || (l_write && l_width[2]) ||
                    ((sz == 2'd1) && l_addr[0]) || ((sz == 2'd2) && (l_addr[1:0] != 2'b00));
`else
  assign fault    = 1'b0;
`endif

  assign access = (state == S_WAIT) && (cnt == 4'd0);

  always_comb begin
    be = 4'b1111;
    wd = l_wdata;
    case (sz)
      2'd0: begin
        be = 4'b0001 << lane;
        wd = {4{l_wdata[7:0]}};
      end
      2'd1: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{l_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = l_wdata;
      end
    endcase
  end

  assign rd_word  = mem[idx];
  assign byte_sel = rd_word[8*lane +: 8];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (sz)
      2'd0:    load_data = l_width[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_data = l_width[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // A reset landing on the access edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && access && l_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
      l_write   <= 1'b0;
      l_addr    <= 32'd0;
      l_wdata   <= 32'd0;
      l_width   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            l_write <= req_write;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_width <= req_width;
            cnt     <= 4'(WAIT_STATES);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
            rsp_rdata <= (l_write || fault) ? 32'd0 : load_data;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with one wait state, one with three for the mid-store reset.
// Fault expectations follow DMEM_CTRL_FAULT_EN.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n, sel3;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_width;

  logic        v1, v3;
  logic        rdy1, vld1, flt1, rdy3, vld3, flt3;
  logic [31:0] rd1, rd3;
  logic [1:0]  st1, st3;
  logic        rdy, vld, flt;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  assign v1  = req_valid & ~sel3;
  assign v3  = req_valid & sel3;
  assign rdy = sel3 ? rdy3 : rdy1;
  assign vld = sel3 ? vld3 : vld1;
  assign flt = sel3 ? flt3 : flt1;
  assign rd  = sel3 ? rd3 : rd1;

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width), .rsp_valid(vld1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_fault(flt1), .dbg_state(st1)
  );

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width), .rsp_valid(vld3),
    .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_fault(flt3), .dbg_state(st3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request with rsp_ready=1; returns data, fault and edges from acceptance to rsp_valid.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                      input logic [2:0] w, output logic [31:0] r, output logic f, output int lat);
    int budget;
    req_write = wr; req_addr = addr; req_wdata = wdat; req_width = w;
    rsp_ready = 1'b1; req_valid = 1'b1;
    r = 32'd0; f = 1'b0; lat = -1;
    budget = 0;
    @(negedge clk);
    while (!rdy && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (vld) begin
        lat = i;
        r = rd;
        f = flt;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL xact_timeout: addr=%h no rsp_valid within 40 cycles", addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_width = 3'b010;
    rsp_ready = 1; sel3 = 0; rst_n = 0; rst3_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; rst3_n = 1;
    @(negedge clk);
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", rdy1); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", vld1); end
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rd1); end
    checks++; if (flt1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault: got %b want 0", flt1); end
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st1); end
    checks++; if (rdy3 !== 1'b1 || vld3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: ready=%b valid=%b want 1/0", rdy3, vld3); end
  endtask

  task automatic test_latency;
    logic [31:0] r; logic f; int lat;
    xact(1'b1, 32'h4, 32'hDEADBEEF, 3'b010, r, f, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (r !== 32'd0 || f !== 1'b0) begin errors++; $display("FAIL sw_rsp: rdata=%h fault=%b want 0/0", r, f); end
    xact(1'b0, 32'h4, 32'h0, 3'b010, r, f, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    checks++; if (r !== 32'hDEADBEEF || f !== 1'b0) begin errors++; $display("FAIL lw_data: rdata=%h fault=%b want deadbeef/0", r, f); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] r; logic f; int lat;
    xact(1'b1, 32'h8, 32'h0000_0000, 3'b010, r, f, lat);
    xact(1'b1, 32'hA, 32'hABCD_EFF0, 3'b000, r, f, lat);
    xact(1'b1, 32'h8, 32'h5555_8001, 3'b001, r, f, lat);
    xact(1'b0, 32'h8, 32'h0, 3'b010, r, f, lat);
    checks++; if (r !== 32'h00F08001) begin errors++; $display("FAIL lanes_lw: got %h want 00f08001", r); end
    xact(1'b0, 32'hA, 32'h0, 3'b000, r, f, lat);
    checks++; if (r !== 32'hFFFFFFF0) begin errors++; $display("FAIL lanes_lb: got %h want fffffff0", r); end
    xact(1'b0, 32'hA, 32'h0, 3'b100, r, f, lat);
    checks++; if (r !== 32'h000000F0) begin errors++; $display("FAIL lanes_lbu: got %h want 000000f0", r); end
    xact(1'b0, 32'h8, 32'h0, 3'b001, r, f, lat);
    checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lanes_lh: got %h want ffff8001", r); end
    xact(1'b0, 32'h8, 32'h0, 3'b101, r, f, lat);
    checks++; if (r !== 32'h00008001) begin errors++; $display("FAIL lanes_lhu: got %h want 00008001", r); end
    xact(1'b0, 32'h9, 32'h0, 3'b100, r, f, lat);
    checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lanes_lbu_lane1: got %h want 00000080", r); end
  endtask

  task automatic test_backpressure;
    int budget;
    logic ok;
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h4; req_width = 3'b010; req_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!rdy && budget < 40) begin @(negedge clk); budget++; end
    @(posedge clk);
    // New request presented and held while the first response is stalled.
    #1 req_addr = 32'h8;
    budget = 0;
    @(negedge clk);
    while (!vld && budget < 40) begin @(negedge clk); budget++; end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", vld); end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vld !== 1'b1 || rd !== 32'hDEADBEEF || rdy !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_hold: valid=%b rdata=%h ready=%b want 1/deadbeef/0", vld, rd, rdy); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 1'b1 || vld !== 1'b0) begin errors++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", rdy, vld); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    budget = 0;
    @(negedge clk);
    while (!vld && budget < 40) begin @(negedge clk); budget++; end
    checks++; if (vld !== 1'b1 || rd !== 32'h00F08001) begin errors++; $display("FAIL bp_second: valid=%b rdata=%h want 1/00f08001", vld, rd); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_faults;
    logic [31:0] r; logic f; int lat;
    xact(1'b1, 32'h0, 32'h0, 3'b010, r, f, lat);
`ifdef DMEM_CTRL_FAULT_EN
    xact(1'b0, 32'h6, 32'h0, 3'b010, r, f, lat);
    checks++; if (f !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL flt_lw_misalign: fault=%b rdata=%h want 1/0", f, r); end
    xact(1'b0, 32'h3, 32'h0, 3'b001, r, f, lat);
    checks++; if (f !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL flt_lh_misalign: fault=%b rdata=%h want 1/0", f, r); end
    xact(1'b1, 32'h1000, 32'h11111111, 3'b010, r, f, lat);
    checks++; if (f !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL flt_sw_range: fault=%b rdata=%h want 1/0", f, r); end
    xact(1'b1, 32'h10, 32'h77, 3'b100, r, f, lat);
    checks++; if (f !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL flt_store_bu: fault=%b rdata=%h want 1/0", f, r); end
    xact(1'b0, 32'h4, 32'h0, 3'b011, r, f, lat);
    checks++; if (f !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL flt_funct3: fault=%b rdata=%h want 1/0", f, r); end
    xact(1'b0, 32'h0, 32'h0, 3'b010, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'd0) begin errors++; $display("FAIL flt_word0: fault=%b rdata=%h want 0/0", f, r); end
`else
    xact(1'b0, 32'h6, 32'h0, 3'b010, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'hDEADBEEF) begin errors++; $display("FAIL nf_lw_align: fault=%b rdata=%h want 0/deadbeef", f, r); end
    xact(1'b0, 32'hB, 32'h0, 3'b001, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'h000000F0) begin errors++; $display("FAIL nf_lh_align: fault=%b rdata=%h want 0/000000f0", f, r); end
    xact(1'b1, 32'h1000, 32'h11111111, 3'b010, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'd0) begin errors++; $display("FAIL nf_sw_wrap: fault=%b rdata=%h want 0/0", f, r); end
    xact(1'b1, 32'h10, 32'h77, 3'b100, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'd0) begin errors++; $display("FAIL nf_store_bu: fault=%b rdata=%h want 0/0", f, r); end
    xact(1'b0, 32'h4, 32'h0, 3'b011, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'hDEADBEEF) begin errors++; $display("FAIL nf_funct3_as_w: fault=%b rdata=%h want 0/deadbeef", f, r); end
    xact(1'b0, 32'h0, 32'h0, 3'b010, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'h11111111) begin errors++; $display("FAIL nf_word0_wrap: fault=%b rdata=%h want 0/11111111", f, r); end
`endif
    xact(1'b0, 32'h4, 32'h0, 3'b010, r, f, lat);
    checks++; if (f !== 1'b0 || r !== 32'hDEADBEEF) begin errors++; $display("FAIL flt_followup: fault=%b rdata=%h want 0/deadbeef", f, r); end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] r; logic f; int lat; int budget;
    sel3 = 1'b1;
    xact(1'b1, 32'hC, 32'hCAFEF00D, 3'b010, r, f, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_latency: got %0d want 4", lat); end
    req_write = 1'b1; req_addr = 32'hC; req_wdata = 32'h12345678; req_width = 3'b010;
    req_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!rdy && budget < 40) begin @(negedge clk); budget++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst3_n = 1'b0;
    @(posedge clk);
    #1 rst3_n = 1'b1;
    @(negedge clk);
    checks++; if (rdy3 !== 1'b1 || vld3 !== 1'b0 || st3 !== 2'd0) begin errors++; $display("FAIL midrst_state: ready=%b valid=%b state=%0d want 1/0/0", rdy3, vld3, st3); end
    xact(1'b0, 32'hC, 32'h0, 3'b010, r, f, lat);
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_data: got %h want cafef00d", r); end
    sel3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_lanes();
    test_backpressure();
    test_faults();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
